// File: rtl/timer_unit_tick_counter.sv
// timer_unit_tick_counter
// Main count stage of the timer unit. It counts prescaler ticks against a
// programmable compare value and emits a one-cycle interrupt pulse on a match.
// Run control (start/stop, one-shot or continuous, clear-on-match) is held in
// a three-state FSM: IDLE, RUN and HALT.
//
// Optional feature macro: TIMER_UNIT_TICK_OVF_EN. When it is defined, the block
// adds a sticky overflow flag on ovf_o, and a counter wrap also pulses irq_o.
//
// Ports:
//   clk_i            clock; all logic runs on its rising edge
//   rst_i            asynchronous, active-high reset
//   tick_i           prescaler tick
//   start_i          one-cycle start request
//   stop_i           one-cycle stop request; wins over start_i
//   clear_i          synchronous counter clear
//   one_shot_i       1 = halt after the first match, 0 = continuous
//   cmp_clr_i        1 = counter returns to 0 on a match
//   write_counter_i  load counter_value_i into the counter
//   counter_value_i  load value
//   compare_value_i  compare value, sampled every cycle
//   counter_value_o  registered counter
//   irq_o            one-cycle match pulse
//   running_o        high while in RUN
//   ovf_o            sticky overflow flag (only with TIMER_UNIT_TICK_OVF_EN)
module timer_unit_tick_counter #(
  parameter int unsigned CNT_W = 32
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             tick_i,
  input  logic             start_i,
  input  logic             stop_i,
  input  logic             clear_i,
  input  logic             one_shot_i,
  input  logic             cmp_clr_i,
  input  logic             write_counter_i,
  input  logic [CNT_W-1:0] counter_value_i,
  input  logic [CNT_W-1:0] compare_value_i,
  output logic [CNT_W-1:0] counter_value_o,
  output logic             irq_o,
`ifdef TIMER_UNIT_TICK_OVF_EN
  output logic             ovf_o,
`endif
  output logic             running_o
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    HALT = 2'd2
  } state_e;

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             irq_q, irq_d;
  logic             run_q, run_d;
  logic             counted_c;
  logic             load_c;
  logic             match_c;
`ifdef TIMER_UNIT_TICK_OVF_EN
  logic             ovf_q, ovf_d;
  logic             wrap_c;
`endif

  // State, counter and output registers
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      irq_q   <= 1'b0;
      run_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      irq_q   <= irq_d;
      run_q   <= run_d;
    end
  end

`ifdef TIMER_UNIT_TICK_OVF_EN
  // Sticky overflow flag
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) ovf_q <= 1'b0;
    else       ovf_q <= ovf_d;
  end
`endif

  // Next-state, counter and output logic
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    counted_c = tick_i && (state_q == RUN);
    // A clear or a load in the same cycle overrides the tick and hides any match.
    load_c    = clear_i || write_counter_i;
    match_c   = counted_c && !load_c && (cnt_q == compare_value_i);
`ifdef TIMER_UNIT_TICK_OVF_EN
    // A return to 0 through clear-on-match is not an overflow.
    wrap_c    = counted_c && !load_c && (cnt_q == '1) && !(match_c && cmp_clr_i);
    ovf_d     = clear_i ? 1'b0 : (ovf_q || wrap_c);
    irq_d     = match_c || wrap_c;
`else
    irq_d     = match_c;
`endif

    unique case (state_q)
      IDLE, HALT: if (start_i && !stop_i) state_d = RUN;
      RUN: begin
        if (stop_i)                      state_d = IDLE;
        else if (match_c && one_shot_i)  state_d = HALT;
      end
      default:                           state_d = IDLE;
    endcase

    if (clear_i)                   cnt_d = '0;
    else if (write_counter_i)      cnt_d = counter_value_i;
    else if (match_c && cmp_clr_i) cnt_d = '0;
    else if (counted_c)            cnt_d = cnt_q + CNT_W'(1);

    run_d = (state_d == RUN);
  end

  assign counter_value_o = cnt_q;
  assign irq_o           = irq_q;
  assign running_o       = run_q;
`ifdef TIMER_UNIT_TICK_OVF_EN
  assign ovf_o           = ovf_q;
`endif

endmodule

// File: tb/tb_timer_unit_tick_counter.sv
// Self-checking bench for timer_unit_tick_counter (CNT_W = 32). The expected
// counter, irq, running and overflow values are queued when each cycle is
// driven. The values sampled after the clock edge are queued next to them,
// and each scenario task compares the two queues.
module tb_timer_unit_tick_counter;

  localparam int unsigned W = 32;
`ifdef TIMER_UNIT_TICK_OVF_EN
  localparam logic OVF = 1'b1;
`else
  localparam logic OVF = 1'b0;
`endif

  typedef struct packed {
    logic [W-1:0] cnt;
    logic         irq;
    logic         run;
    logic         ovf;
  } smp_t;

  logic         clk_i = 1'b0;
  logic         rst_i = 1'b0;
  logic         tick_i = 1'b0, start_i = 1'b0, stop_i = 1'b0, clear_i = 1'b0;
  logic         one_shot_i = 1'b0, cmp_clr_i = 1'b0, write_counter_i = 1'b0;
  logic [W-1:0] counter_value_i = '0, compare_value_i = '0;
  logic [W-1:0] counter_value_o;
  logic         irq_o, running_o;
  logic         ovf_s;
`ifdef TIMER_UNIT_TICK_OVF_EN
  logic         ovf_o;
  assign ovf_s = ovf_o;
`else
  assign ovf_s = 1'b0;
`endif

  smp_t exp_q[$];
  smp_t obs_q[$];
  int   n_vec = 0;
  int   n_err = 0;

  timer_unit_tick_counter #(.CNT_W(W)) dut (
    .clk_i(clk_i), .rst_i(rst_i), .tick_i(tick_i), .start_i(start_i),
    .stop_i(stop_i), .clear_i(clear_i), .one_shot_i(one_shot_i),
    .cmp_clr_i(cmp_clr_i), .write_counter_i(write_counter_i),
    .counter_value_i(counter_value_i), .compare_value_i(compare_value_i),
    .counter_value_o(counter_value_o), .irq_o(irq_o),
`ifdef TIMER_UNIT_TICK_OVF_EN
    .ovf_o(ovf_o),
`endif
    .running_o(running_o)
  );

  always #5 clk_i = ~clk_i;

  // Drive one cycle of stimulus, queue its expectation, and capture the result.
  task automatic cyc(input logic t, s, p, c, w, input logic [W-1:0] wv,
                     input logic [W-1:0] ecnt, input logic eirq, erun, eovf);
    tick_i = t; start_i = s; stop_i = p; clear_i = c;
    write_counter_i = w; counter_value_i = wv;
    exp_q.push_back('{ecnt, eirq, erun, eovf});
    @(posedge clk_i); #1;
    obs_q.push_back('{counter_value_o, irq_o, running_o, ovf_s});
    tick_i = 0; start_i = 0; stop_i = 0; clear_i = 0; write_counter_i = 0;
  endtask

  task automatic test_reset;
    rst_i = 1'b1;
    #12;
    n_vec++;
    if ({counter_value_o, irq_o, running_o, ovf_s} !== {{W{1'b0}}, 3'b000}) begin
      n_err++;
      $display("FAIL reset: cnt=%h irq=%b run=%b ovf=%b, want all 0",
               counter_value_o, irq_o, running_o, ovf_s);
    end
    @(posedge clk_i); #1;
    rst_i = 1'b0;
  endtask

  task automatic test_idle_ticks;
    smp_t e, o;
    int   i = 0;
    compare_value_i = '0; cmp_clr_i = 0; one_shot_i = 0;
    repeat (4) cyc(1, 0, 0, 0, 0, '0, '0, 0, 0, 0);
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front(); o = obs_q.pop_front(); n_vec++;
      if (o !== e) begin
        n_err++;
        $display("FAIL idle_ticks[%0d]: got cnt=%h irq=%b run=%b ovf=%b want cnt=%h irq=%b run=%b ovf=%b",
                 i, o.cnt, o.irq, o.run, o.ovf, e.cnt, e.irq, e.run, e.ovf);
      end
      i++;
    end
  endtask

  task automatic test_continuous;
    smp_t e, o;
    int   i = 0;
    compare_value_i = 32'd3; cmp_clr_i = 1; one_shot_i = 0;
    cyc(0, 1, 0, 0, 0, '0, '0, 0, 1, 0);
    for (int k = 0; k < 8; k++)
      cyc(1, 0, 0, 0, 0, '0, W'((k + 1) % 4), (k % 4) == 3, 1, 0);
    cyc(0, 0, 1, 0, 0, '0, '0, 0, 0, 0);
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front(); o = obs_q.pop_front(); n_vec++;
      if (o !== e) begin
        n_err++;
        $display("FAIL continuous[%0d]: got cnt=%h irq=%b run=%b ovf=%b want cnt=%h irq=%b run=%b ovf=%b",
                 i, o.cnt, o.irq, o.run, o.ovf, e.cnt, e.irq, e.run, e.ovf);
      end
      i++;
    end
  endtask

  task automatic test_back_to_back;
    smp_t e, o;
    int   i = 0;
    compare_value_i = '0; cmp_clr_i = 1; one_shot_i = 0;
    cyc(0, 1, 0, 0, 0, '0, '0, 0, 1, 0);
    repeat (3) cyc(1, 0, 0, 0, 0, '0, '0, 1, 1, 0);
    cyc(0, 0, 0, 0, 0, '0, '0, 0, 1, 0);
    cyc(0, 0, 1, 0, 0, '0, '0, 0, 0, 0);
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front(); o = obs_q.pop_front(); n_vec++;
      if (o !== e) begin
        n_err++;
        $display("FAIL back_to_back[%0d]: got cnt=%h irq=%b run=%b ovf=%b want cnt=%h irq=%b run=%b ovf=%b",
                 i, o.cnt, o.irq, o.run, o.ovf, e.cnt, e.irq, e.run, e.ovf);
      end
      i++;
    end
  endtask

  task automatic test_one_shot;
    smp_t e, o;
    int   i = 0;
    compare_value_i = 32'd2; cmp_clr_i = 0; one_shot_i = 1;
    cyc(0, 1, 0, 0, 0, '0, '0, 0, 1, 0);
    for (int k = 0; k < 3; k++) begin
      repeat (3) cyc(0, 0, 0, 0, 0, '0, W'(k), 0, 1, 0);
      cyc(1, 0, 0, 0, 0, '0, W'(k + 1), k == 2, k != 2, 0);
    end
    repeat (4) cyc(1, 0, 0, 0, 0, '0, 32'd3, 0, 0, 0);
    cyc(0, 1, 0, 0, 0, '0, 32'd3, 0, 1, 0);
    cyc(1, 0, 0, 0, 0, '0, 32'd4, 0, 1, 0);
    cyc(0, 0, 1, 0, 0, '0, 32'd4, 0, 0, 0);
    one_shot_i = 0;
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front(); o = obs_q.pop_front(); n_vec++;
      if (o !== e) begin
        n_err++;
        $display("FAIL one_shot[%0d]: got cnt=%h irq=%b run=%b ovf=%b want cnt=%h irq=%b run=%b ovf=%b",
                 i, o.cnt, o.irq, o.run, o.ovf, e.cnt, e.irq, e.run, e.ovf);
      end
      i++;
    end
  endtask

  task automatic test_wrap;
    smp_t e, o;
    int   i = 0;
    compare_value_i = 32'h10; cmp_clr_i = 0; one_shot_i = 0;
    cyc(0, 0, 0, 0, 1, 32'hFFFF_FFFE, 32'hFFFF_FFFE, 0, 0, 0);
    cyc(0, 1, 0, 0, 0, '0, 32'hFFFF_FFFE, 0, 1, 0);
    cyc(1, 0, 0, 0, 0, '0, 32'hFFFF_FFFF, 0, 1, 0);
    cyc(1, 0, 0, 0, 0, '0, 32'h0, OVF, 1, OVF);
    cyc(1, 0, 0, 0, 0, '0, 32'h1, 0, 1, OVF);
    cyc(0, 0, 0, 1, 0, '0, 32'h0, 0, 1, 0);
    cyc(0, 0, 1, 0, 0, '0, 32'h0, 0, 0, 0);
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front(); o = obs_q.pop_front(); n_vec++;
      if (o !== e) begin
        n_err++;
        $display("FAIL wrap[%0d]: got cnt=%h irq=%b run=%b ovf=%b want cnt=%h irq=%b run=%b ovf=%b",
                 i, o.cnt, o.irq, o.run, o.ovf, e.cnt, e.irq, e.run, e.ovf);
      end
      i++;
    end
  endtask

  task automatic test_clear_collision;
    smp_t e, o;
    int   i = 0;
    compare_value_i = 32'd5; cmp_clr_i = 0; one_shot_i = 0;
    cyc(0, 1, 0, 0, 0, '0, 32'd0, 0, 1, 0);
    cyc(0, 0, 0, 0, 1, 32'd5, 32'd5, 0, 1, 0);
    cyc(1, 0, 0, 1, 0, '0, 32'd0, 0, 1, 0);
    cyc(1, 0, 0, 0, 0, '0, 32'd1, 0, 1, 0);
    cyc(0, 0, 0, 0, 1, 32'd5, 32'd5, 0, 1, 0);
    cyc(1, 0, 0, 0, 1, 32'd9, 32'd9, 0, 1, 0);
    compare_value_i = 32'd9;
    cyc(1, 0, 0, 0, 0, '0, 32'd10, 1, 1, 0);
    cyc(0, 0, 1, 0, 0, '0, 32'd10, 0, 0, 0);
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front(); o = obs_q.pop_front(); n_vec++;
      if (o !== e) begin
        n_err++;
        $display("FAIL clear_collision[%0d]: got cnt=%h irq=%b run=%b ovf=%b want cnt=%h irq=%b run=%b ovf=%b",
                 i, o.cnt, o.irq, o.run, o.ovf, e.cnt, e.irq, e.run, e.ovf);
      end
      i++;
    end
  endtask

  task automatic test_start_stop;
    smp_t e, o;
    int   i = 0;
    compare_value_i = 32'd5; cmp_clr_i = 0; one_shot_i = 0;
    cyc(0, 1, 0, 0, 0, '0, 32'd10, 0, 1, 0);
    cyc(0, 1, 1, 0, 0, '0, 32'd10, 0, 0, 0);
    cyc(0, 1, 1, 0, 0, '0, 32'd10, 0, 0, 0);
    cyc(0, 1, 0, 0, 0, '0, 32'd10, 0, 1, 0);
    cyc(0, 0, 0, 0, 1, 32'd6, 32'd6, 0, 1, 0);
    cyc(1, 0, 0, 0, 0, '0, 32'd7, 0, 1, 0);
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front(); o = obs_q.pop_front(); n_vec++;
      if (o !== e) begin
        n_err++;
        $display("FAIL start_stop[%0d]: got cnt=%h irq=%b run=%b ovf=%b want cnt=%h irq=%b run=%b ovf=%b",
                 i, o.cnt, o.irq, o.run, o.ovf, e.cnt, e.irq, e.run, e.ovf);
      end
      i++;
    end
    // Reset asserted between clock edges must take effect at once.
    tick_i = 1;
    #2 rst_i = 1'b1;
    #1;
    n_vec++;
    if ({counter_value_o, running_o, irq_o} !== {{W{1'b0}}, 2'b00}) begin
      n_err++;
      $display("FAIL async_reset: cnt=%h run=%b irq=%b, want cnt=0 run=0 irq=0",
               counter_value_o, running_o, irq_o);
    end
    @(posedge clk_i); #1;
    rst_i = 1'b0; tick_i = 0;
    cyc(1, 0, 0, 0, 0, '0, 32'd0, 0, 0, 0);
    i = 0;
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front(); o = obs_q.pop_front(); n_vec++;
      if (o !== e) begin
        n_err++;
        $display("FAIL post_reset[%0d]: got cnt=%h irq=%b run=%b ovf=%b want cnt=%h irq=%b run=%b ovf=%b",
                 i, o.cnt, o.irq, o.run, o.ovf, e.cnt, e.irq, e.run, e.ovf);
      end
      i++;
    end
  endtask

  initial begin
    #1;
    test_reset;
    test_idle_ticks;
    test_continuous;
    test_back_to_back;
    test_one_shot;
    test_wrap;
    test_clear_collision;
    test_start_stop;
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
